// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial a - b - bin: one 4-bit carry-lookahead slice per CALC cycle,
// LSB first, with a valid/ready handshake on both sides.
module nibble_serial_subtractor #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   bin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   diff,
    output logic                   bout,
    output logic                   ovf
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic [W-1:0]       r_diff;
    logic               r_bout;
    logic               r_ovf;
    logic [3:0]         w_x;
    logic [3:0]         w_y;
    logic [4:0]         w_slice;
    logic               w_last;

    // Returns {C4, sum[3:0]} of x + y + c0 using generate/propagate lookahead.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic c0);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c[4], p ^ c[3:0]};
    endfunction

    always_comb begin
        w_x = '0;
        w_y = '0;
        for (int k = 0; k < NIBBLES; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_x = r_a[4*k +: 4];
                w_y = ~r_b[4*k +: 4];
            end
        end
        w_slice = cla4(w_x, w_y, r_carry);
        w_last  = (r_idx == IDX_W'(NIBBLES - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_next = S_CALC;
            S_CALC:  if (w_last)    w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Borrow-in enters as an inverted carry so a + ~b + ~bin == a - b - bin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= ~bin;
                        r_idx   <= '0;
                    end
                end
                S_CALC: begin
                    for (int k = 0; k < NIBBLES; k++) begin
                        if (r_idx == IDX_W'(k)) begin
                            r_diff[4*k +: 4] <= w_slice[3:0];
                        end
                    end
                    r_carry <= w_slice[4];
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_bout <= ~w_slice[4];
                        r_ovf  <= (r_a[W-1] ^ r_b[W-1]) & (r_a[W-1] ^ w_slice[3]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Bench for nibble_serial_subtractor: directed corner cases, backpressure,
// mid-operation reset and a long random run against an arithmetic model.
module tb_nibble_serial_subtractor;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         bin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int total = 0;
    int bad   = 0;

    nibble_serial_subtractor #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: {ovf, bout, diff} from integer arithmetic on the operands.
    function automatic logic [W+1:0] ref_sub(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                             input logic xbin);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        int u;
        int s;
        logic [W-1:0] d;
        logic bo;
        logic ov;
        sa = xa;
        sb = xb;
        u  = int'(xa) - int'(xb) - int'(xbin);
        s  = int'(sa) - int'(sb) - int'(xbin);
        d  = u[W-1:0];
        bo = (u < 0);
        ov = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
        return {ov, bo, d};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic xbin, input int stall);
        logic [W+1:0] e;
        int lat;
        e   = ref_sub(xa, xb, xbin);
        lat = 0;
        while (!in_ready && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        a         = xa;
        b         = xb;
        bin       = xbin;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        bin      = 1'($urandom);
        lat      = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(N));
        repeat (stall) tick();
        check({tag, " diff"}, 32'(diff), 32'(e[W-1:0]));
        check({tag, " bout"}, 32'(bout), 32'(e[W]));
        check({tag, " ovf"},  32'(ovf),  32'(e[W+1]));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] held;
        int sel;
        int stall;

        #2 rst_n = 1'b0;
        #1;
        check("rst in_ready",  32'(in_ready),  32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst diff",      32'(diff),      32'd0);
        check("rst bout",      32'(bout),      32'd0);
        check("rst ovf",       32'(ovf),       32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        run_op("d1234", 16'h1234, 16'h0234, 1'b0, 0);
        check("post hs out_valid", 32'(out_valid), 32'd0);
        check("post hs in_ready",  32'(in_ready),  32'd1);
        check("post hs diff hold", 32'(diff),      32'h1000);
        run_op("d0m1",    16'h0000, 16'h0001, 1'b0, 2);
        run_op("d8000m1", 16'h8000, 16'h0001, 1'b0, 0);
        run_op("d5m3b",   16'h0005, 16'h0003, 1'b1, 0);
        run_op("d3m3b",   16'h0003, 16'h0003, 1'b1, 1);
        run_op("dovfbin", 16'h8000, 16'h7FFF, 1'b1, 0);

        // Backpressure: 10 stalled DONE cycles with noisy inputs.
        a        = 16'h00F0;
        b        = 16'h0F00;
        bin      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (N) tick();
        check("bp out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = ~in_valid;
            a        = W'($urandom);
            b        = W'($urandom);
            tick();
            check("bp hold valid", 32'(out_valid), 32'd1);
            check("bp hold diff",  32'(diff),      32'hF1F0);
            check("bp hold bout",  32'(bout),      32'd1);
            check("bp hold ovf",   32'(ovf),       32'd0);
            check("bp in_ready",   32'(in_ready),  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp release valid", 32'(out_valid), 32'd0);
        check("bp release ready", 32'(in_ready),  32'd1);

        // Reset after nibble 1 of an operation.
        a        = 16'h5555;
        b        = 16'h1111;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort diff",      32'(diff),      32'd0);
        check("abort in_ready",  32'(in_ready),  32'd1);
        check("abort bout",      32'(bout),      32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort no result", 32'(out_valid), 32'd0);
        end
        run_op("after abort", 16'hFFFF, 16'h0001, 1'b0, 0);
        held = diff;
        check("after abort held", 32'(held), 32'hFFFE);

        // Random back-to-back run with occasional stalls and operand corners.
        for (int i = 0; i < 10000; i++) begin
            sel = $urandom_range(0, 15);
            ra  = W'($urandom);
            rb  = W'($urandom);
            case (sel)
                0: begin ra = '0; rb = '0; end
                1: begin ra = '1; rb = '1; end
                2: begin ra = '0; rb = '1; end
                3: begin ra = '1; rb = '0; end
                default: ;
            endcase
            stall = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            run_op("rnd", ra, rb, 1'($urandom), stall);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nibble_serial_subtractor.md
NIBBLE_SERIAL_SUBTRACTOR -- requirements
Module: nibble_serial_subtractor

Interface
REQ-001 The block SHALL have one parameter: NIBBLES, default 4, number of 4-bit slices; data width W = 4*NIBBLES.
REQ-002 Port clk, input, 1, sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port in_valid, input, 1, operand set present.
REQ-005 Port in_ready, output, 1, block can accept operands.
REQ-006 Port a, input, W, minuend (unsigned or two's complement).
REQ-007 Port b, input, W, subtrahend.
REQ-008 Port bin, input, 1, borrow in.
REQ-009 Port out_valid, output, 1, result present.
REQ-010 Port out_ready, input, 1, consumer accepts result.
REQ-011 Port diff, output, W, a - b - bin modulo 2^W.
REQ-012 Port bout, output, 1, borrow out (1 when a < b + bin, unsigned).
REQ-013 Port ovf, output, 1, signed overflow of the subtraction.

Function
REQ-014 The block SHALL be an FSM with states IDLE, CALC, DONE.
REQ-015 The block SHALL drive in_ready = 1 only in IDLE and 0 in all other states.
REQ-016 In IDLE, on the edge where in_valid and in_ready are both 1, the block SHALL register a, b and carry = ~bin, clear the slice index to 0, and enter CALC.
REQ-017 The block SHALL ignore in_valid and operand changes outside IDLE.
REQ-018 Each CALC cycle SHALL process exactly one nibble i, least significant first.
REQ-019 The nibble result SHALL be computed as a[i] + ~b[i] + carry, using generate/propagate carry-lookahead within the slice (G = x&y, P = x^y, C1..C4 from G, P and carry-in), not a ripple chain.
REQ-020 Each CALC cycle SHALL write the 4-bit sum into diff[4i+3:4i] and store C4 as the next carry.
REQ-021 After the cycle processing nibble NIBBLES-1, the block SHALL enter DONE.
REQ-022 On the transition into DONE, the block SHALL set bout = ~final carry and ovf = (a[W-1]^b[W-1]) & (a[W-1]^diff[W-1]).
REQ-023 Latency: with acceptance at edge T, out_valid SHALL be 1 after edge T+NIBBLES (T+4 by default).
REQ-024 The block SHALL hold out_valid = 1 only in DONE.
REQ-025 In DONE, diff, bout and ovf SHALL remain stable while out_ready = 0, for any number of cycles.
REQ-026 In DONE, when out_ready = 1 at an edge, the block SHALL return to IDLE with out_valid = 0; diff, bout and ovf SHALL hold their last values.
REQ-027 The block SHALL have no combinational path from out_ready or in_valid to any output.
REQ-028 The minimum initiation interval SHALL be NIBBLES+2 cycles (accept, NIBBLES x CALC, DONE handshake).

Reset
REQ-029 While rst_n = 0, independent of clk, the block SHALL force state = IDLE, in_ready = 1, out_valid = 0, diff = 0, bout = 0, ovf = 0, and clear carry, index and operand registers.
REQ-030 Reset asserted in CALC or DONE SHALL abort the operation; no result for that operation SHALL ever be presented.
REQ-031 After rst_n deasserts, the block SHALL accept operands on the first rising edge at which in_valid = 1.

Verification
REQ-032 a=0x1234, b=0x0234, bin=0 -> diff=0x1000, bout=0, ovf=0, out_valid 4 cycles after acceptance.
REQ-033 a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0; and a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1.
REQ-034 a=0x0005, b=0x0003, bin=1 -> diff=0x0001, bout=0; and a=0x0003, b=0x0003, bin=1 -> diff=0xFFFF, bout=1.
REQ-035 Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and a/b -> out_valid, diff, bout and ovf stable, in_ready=0; after out_ready=1 -> IDLE and in_ready=1 next cycle.
REQ-036 Reset mid-CALC (rst_n low after nibble 1) -> immediate out_valid=0, diff=0, in_ready=1; the next operation a=0xFFFF, b=0x0001 -> diff=0xFFFE, with no trace of the aborted operation.
REQ-037 Random test: 10k back-to-back operations with random out_ready stalls, compared against the reference a-b-bin model, including all-zero and all-one operand corners -> zero mismatches.
